// File: rtl/div_usg_seq.sv
// -----------------------------------------------------------------------------
// div_usg_seq
//   Sequential unsigned restoring divider. This is the inverse of the unsigned
//   array multiplier and serves as the mantissa divide stage of the FP datapath.
//   It computes quotient = dividend / divisor and remainder = dividend % divisor.
//   One quotient bit is produced per clock, MSB first. Both the input and the
//   output side use a valid/ready handshake.
//
// Ports
//   clk          in   1    clock, rising edge
//   rst_n        in   1    asynchronous reset, active low
//   in_valid     in   1    dividend/divisor valid
//   in_ready     out  1    block can accept an operation (state IDLE)
//   dividend     in   2N   A, unsigned
//   divisor      in   N    B, unsigned
//   out_valid    out  1    result valid (state DONE)
//   out_ready    in   1    downstream accepts result
//   quotient     out  2N   Q, unsigned (all ones on divide by zero)
//   remainder    out  N    R, unsigned (A[N-1:0] on divide by zero)
//   div_by_zero  out  1    set with the result when B == 0
// -----------------------------------------------------------------------------
module div_usg_seq #(
    parameter int N = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [2*N-1:0] a_q;      // dividend, shifted out MSB first
    logic [N-1:0]   b_q;      // latched divisor
    logic [N:0]     p_q;      // partial remainder; the extra bit keeps the compare/subtract from overflowing
    logic [2*N-1:0] q_work;   // quotient being assembled
    logic [CW-1:0]  cnt;      // restoring steps still to do

    logic [N:0]     p_shift;
    logic [N:0]     p_next;
    logic           q_bit;

    // One restoring step. Every signal here is assigned on every path.
    // NOTE: a path that leaves a variable unassigned in always_comb infers a latch.
    always_comb begin
        p_shift = {p_q[N-1:0], a_q[2*N-1]};
        q_bit   = (p_shift >= {1'b0, b_q});
        p_next  = q_bit ? (p_shift - {1'b0, b_q}) : p_shift;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            q_work      <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= dividend;
                        b_q    <= divisor;
                        p_q    <= '0;
                        q_work <= '0;
                        if (divisor != '0) begin
                            cnt         <= CW'(2*N);
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end else begin
                            // Divide by zero: the result is ready at once.
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end

                RUN: begin
                    p_q    <= p_next;
                    a_q    <= {a_q[2*N-2:0], 1'b0};
                    q_work <= {q_work[2*N-2:0], q_bit};
                    cnt    <= cnt - CW'(1);
                    // On the last step, the result goes straight into the output registers.
                    // The outputs stay frozen during RUN until this point.
                    if (cnt == CW'(1)) begin
                        quotient  <= {q_work[2*N-2:0], q_bit};
                        remainder <= p_next[N-1:0];
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
